// File: rtl/fb_write_arbiter.sv
// Purpose: round-robin arbiter sharing one framebuffer pixel-write port among cursor (0), brush (1) and clear sweeper (2).
// Latency: fb_wr is high for WR_CYCLES cycles starting 1 cycle after grant; ack follows; WR_CYCLES+2 cycles per write.
// Backpressure: requesters hold req with stable x/y/d until ack; inputs are sampled only in IDLE.
module fb_write_arbiter #(
    parameter int COORD_W   = 6,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         req,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [DATA_W-1:0]  d0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [DATA_W-1:0]  d1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [DATA_W-1:0]  d2,
    output logic [2:0]         ack,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [DATA_W-1:0]  fb_data,
    output logic               fb_wr,
    output logic               busy,
    output logic [1:0]         last_grant
);

    // A one-cycle write still needs a 1-bit counter so the compare stays legal.
    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [COORD_W-1:0] fb_x_q, fb_x_d;
    logic [COORD_W-1:0] fb_y_q, fb_y_d;
    logic [DATA_W-1:0]  fb_data_q, fb_data_d;
    logic               fb_wr_q, fb_wr_d;
    logic               busy_q, busy_d;
    logic [2:0]         ack_q, ack_d;

    logic [1:0]         pick;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [DATA_W-1:0]  sel_d;

    // Round-robin pick: scan starting just after the last served requester.
    always_comb begin
        pick = 2'd0;
        case (last_grant_q)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Steer the picked requester's coordinate and pixel toward the latch.
    always_comb begin
        sel_x = x0;
        sel_y = y0;
        sel_d = d0;
        case (pick)
            2'd1: begin
                sel_x = x1;
                sel_y = y1;
                sel_d = d1;
            end
            2'd2: begin
                sel_x = x2;
                sel_y = y2;
                sel_d = d2;
            end
            default: ;
        endcase
    end

    // FSM next state: grant in IDLE, hold the write for WR_CYCLES, pulse ack once.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        fb_x_d       = fb_x_q;
        fb_y_d       = fb_y_q;
        fb_data_d    = fb_data_q;
        fb_wr_d      = fb_wr_q;
        busy_d       = busy_q;
        ack_d        = 3'b000;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = pick;
                    fb_x_d    = sel_x;
                    fb_y_d    = sel_y;
                    fb_data_d = sel_d;
                    fb_wr_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    fb_wr_d      = 1'b0;
                    ack_d        = 3'b001 << grant_q;
                    last_grant_d = grant_q;
                    state_d      = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                fb_wr_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any write in flight without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_data_q    <= '0;
            fb_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            fb_x_q       <= fb_x_d;
            fb_y_q       <= fb_y_d;
            fb_data_q    <= fb_data_d;
            fb_wr_q      <= fb_wr_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_data    = fb_data_q;
    assign fb_wr      = fb_wr_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single framebuffer pixel-write port among three requesters: cursor draw controller (0), brush/paint engine (1) and clear-screen sweeper (2).
- Round-robin arbitration. The winner's coordinate and pixel byte are latched, and one write is driven for a programmable number of cycles. The winner then receives a one-cycle acknowledge.
- Sits between the paint-side controllers and the framebuffer RAM write interface.

Parameters:
- COORD_W, 6, width of x and y coordinates (64x64 panel).
- DATA_W, 8, pixel data width.
- WR_CYCLES, 2, cycles fb_wr is held per write. Must be >= 1; 0 is illegal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  request per requester, bit i = requester i.
- x0, y0  in  COORD_W each  requester 0 coordinate.
- d0  in  DATA_W  requester 0 pixel data.
- x1, y1  in  COORD_W each  requester 1 coordinate.
- d1  in  DATA_W  requester 1 pixel data.
- x2, y2  in  COORD_W each  requester 2 coordinate.
- d2  in  DATA_W  requester 2 pixel data.
- ack  out  3  one-cycle pulse on bit i when requester i's write is complete.
- fb_x, fb_y  out  COORD_W each  framebuffer write address.
- fb_data  out  DATA_W  framebuffer write data.
- fb_wr  out  1  framebuffer write enable.
- busy  out  1  high while a transaction is in progress (any state other than IDLE).
- last_grant  out  2  index of the most recently served requester.

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; fb_wr=0, ack=0, busy=0.
  - fb_x=0, fb_y=0, fb_data=0.
  - last_grant=2, so requester 0 has first priority.
  - Write-cycle counter=0.
  - Reset overrides everything, including a write in progress. fb_wr is 0 from the first edge with rst=1. No ack is issued for an aborted write.
- Requester contract:
  - Raise req[i] with x/y/d stable and hold until ack[i].
  - May drop req[i] in the cycle after ack, or keep it high with new x/y/d for a back-to-back write.
- State machine:
  - IDLE
    - If req==0: stay.
    - Otherwise pick the first set bit scanning last_grant+1, +2, +3 (mod 3).
    - Latch that requester's x/y/d into fb_x/fb_y/fb_data; set fb_wr=1, busy=1; counter=WR_CYCLES-1; go WRITE.
  - WRITE
    - fb_wr stays 1 and address/data stay frozen.
    - If counter==0: fb_wr=0, ack[g]=1, last_grant=g, go ACK. Otherwise counter decrements.
    - fb_wr is therefore high for exactly WR_CYCLES cycles.
  - ACK
    - ack=0, busy=0, go IDLE. fb_x/fb_y/fb_data keep their last values.
- Latency:
  - req rising in cycle 0: fb_wr high in cycles 1..WR_CYCLES.
  - ack high in cycle WR_CYCLES+1.
  - Next grant decision in cycle WR_CYCLES+2.
  - Per-write occupancy is WR_CYCLES+2 cycles.
- Boundary conditions:
  - Requester inputs are sampled only in IDLE. Changes to x/y/d or req during WRITE/ACK do not affect the current write.
  - req[i] dropped after grant: the write still completes and ack[i] still pulses.
  - req[i] dropped before being granted: never served, no ack.
  - Simultaneous requests are resolved purely round-robin. With all three held continuously the grant order is 0,1,2,0,... No requester waits more than two transactions.
  - A requester with req still high in ACK is evaluated in the following IDLE cycle like any other. It has lowest priority because it equals last_grant.
  - Only one ack bit is ever high, and only in ACK.
  - fb_wr and ack are never high in the same cycle.
  - Coordinate and data widths pass through unchanged; no arithmetic on them.

Test Plan:
- Single request: rst, then req=3'b010, x1=5, y1=9, d1=8'hFF. fb_wr high cycles 1-2 with fb_x=5, fb_y=9, fb_data=FF. ack=3'b010 in cycle 3. last_grant=1, busy low in cycle 4.
- Simultaneous: req=3'b111 held, distinct data per requester. Writes occur in order 0,1,2,0. Each ack is a single cycle, spaced 4 cycles apart.
- Fairness: req0 and req1 held high continuously for 8 transactions. Grants alternate 0,1,0,1,...; requester 2 is never acked.
- Withdrawal:
  - req2 drops during WRITE: write completes, ack[2] pulses.
  - req0 pulses for one cycle while requester 2 is being served: no write to requester 0's address, no ack[0].
- Reset mid-write: assert rst during the first WRITE cycle. Next edge: fb_wr=0, ack=0, busy=0, last_grant=2. After rst drops with req=3'b001, requester 0 is served normally.
- WR_CYCLES=1 build: single request gives fb_wr high exactly one cycle and ack the following cycle. Back-to-back requests from one requester yield one write every 3 cycles.
